// File: rtl/lcd_hd44780_ctrl.sv
// HD44780-class character-LCD write controller: power-up wait, init table, then valid/ready byte writes.
// Define LCD_FOURBIT_EN to build the 4-bit bus variant (nibble sequencing on LCD_DATA[7:4]).
module lcd_hd44780_ctrl #(
  parameter int unsigned PWRUP_WAIT_CYC = 750000,
  parameter int unsigned EN_HIGH_CYC    = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLR_WAIT_CYC   = 82000,
  parameter logic [7:0]  ENTRY_MODE     = 8'h06
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_SETTLE
  } state_t;

`ifdef LCD_FOURBIT_EN
  // single: one nibble only (wake-up writes); force_clr: long settle regardless of value
  typedef struct packed {
    logic       single;
    logic       force_clr;
    logic [7:0] val;
  } init_entry_t;
  localparam int INIT_LEN = 8;
`else
  typedef struct packed {
    logic [7:0] val;
  } init_entry_t;
  localparam int INIT_LEN = 4;
`endif

  localparam logic [23:0] PWRUP_LAST  = 24'(PWRUP_WAIT_CYC - 1);
  localparam logic [23:0] STROBE_LAST = 24'(EN_HIGH_CYC - 1);
  localparam logic [23:0] CMD_LAST    = 24'(CMD_WAIT_CYC - 1);
  localparam logic [23:0] CLR_LAST    = 24'(CLR_WAIT_CYC - 1);

  function automatic init_entry_t init_entry(input logic [3:0] idx);
    init_entry_t e;
`ifdef LCD_FOURBIT_EN
    case (idx)
      4'd0:    e = '{single: 1'b1, force_clr: 1'b1, val: 8'h30};
      4'd1:    e = '{single: 1'b1, force_clr: 1'b0, val: 8'h30};
      4'd2:    e = '{single: 1'b1, force_clr: 1'b0, val: 8'h30};
      4'd3:    e = '{single: 1'b1, force_clr: 1'b0, val: 8'h20};
      4'd4:    e = '{single: 1'b0, force_clr: 1'b0, val: 8'h28};
      4'd5:    e = '{single: 1'b0, force_clr: 1'b0, val: 8'h0C};
      4'd6:    e = '{single: 1'b0, force_clr: 1'b0, val: 8'h01};
      default: e = '{single: 1'b0, force_clr: 1'b0, val: ENTRY_MODE};
    endcase
`else
    case (idx)
      4'd0:    e = '{val: 8'h38};
      4'd1:    e = '{val: 8'h0C};
      4'd2:    e = '{val: 8'h01};
      default: e = '{val: ENTRY_MODE};
    endcase
`endif
    return e;
  endfunction

  state_t      state, state_next;
  logic [23:0] cnt;
  logic [7:0]  byte_q;
  logic        rs_q;
  logic [3:0]  init_idx;
  logic        accept;
  logic        is_clr;
  logic [23:0] wait_last;
  logic        cnt_clr, load_init, load_wr, done_set;
  init_entry_t entry;
`ifdef LCD_FOURBIT_EN
  logic        single_q, force_clr_q, phase_lo, phase_set;
`endif

  assign LCD_RW = 1'b0;
  assign accept = wr_valid & wr_ready;
  assign entry  = init_entry(init_idx);

`ifdef LCD_FOURBIT_EN
  assign is_clr = force_clr_q | (~rs_q & (byte_q inside {8'h01, 8'h02, 8'h03}));
`else
  assign is_clr = ~rs_q & (byte_q inside {8'h01, 8'h02, 8'h03});
`endif
  assign wait_last = is_clr ? CLR_LAST : CMD_LAST;

  // NOTE: every output of this block gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    load_init  = 1'b0;
    load_wr    = 1'b0;
    done_set   = 1'b0;
`ifdef LCD_FOURBIT_EN
    phase_set  = 1'b0;
`endif
    unique case (state)
      S_PWRUP: if (cnt == PWRUP_LAST) begin
        cnt_clr    = 1'b1;
        state_next = S_INIT;
      end
      S_INIT: begin
        load_init  = 1'b1;
        cnt_clr    = 1'b1;
        state_next = S_SETUP;
      end
      S_IDLE: if (accept) begin
        load_wr    = 1'b1;
        cnt_clr    = 1'b1;
        state_next = S_SETUP;
      end
      S_SETUP: begin
        cnt_clr    = 1'b1;
        state_next = S_STROBE;
      end
      S_STROBE: if (cnt == STROBE_LAST) begin
        cnt_clr    = 1'b1;
        state_next = S_SETTLE;
`ifdef LCD_FOURBIT_EN
        // High nibble done: the low nibble's setup cycle is the only EN-low gap
        if (!phase_lo && !single_q) begin
          phase_set  = 1'b1;
          state_next = S_SETUP;
        end
`endif
      end
      S_SETTLE: if (cnt == wait_last) begin
        cnt_clr = 1'b1;
        if (init_done) begin
          state_next = S_IDLE;
        end else if (init_idx == 4'(INIT_LEN)) begin
          done_set   = 1'b1;
          state_next = S_IDLE;
        end else begin
          load_init  = 1'b1;
          state_next = S_SETUP;
        end
      end
      default: state_next = S_PWRUP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_PWRUP;
      cnt       <= '0;
      byte_q    <= '0;
      rs_q      <= 1'b0;
      init_idx  <= '0;
      init_done <= 1'b0;
      wr_ready  <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= '0;
`ifdef LCD_FOURBIT_EN
      single_q    <= 1'b0;
      force_clr_q <= 1'b0;
      phase_lo    <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_clr ? '0 : cnt + 24'd1;
      init_done <= init_done | done_set;
      // Registered from the current state: ready lags IDLE entry by one cycle and drops after a handshake
      wr_ready  <= (state == S_IDLE) && !accept;
      LCD_EN    <= (state == S_STROBE);

      if (load_init) begin
        byte_q   <= entry.val;
        rs_q     <= 1'b0;
        init_idx <= init_idx + 4'd1;
`ifdef LCD_FOURBIT_EN
        single_q    <= entry.single;
        force_clr_q <= entry.force_clr;
`endif
      end else if (load_wr) begin
        byte_q <= wr_data;
        rs_q   <= wr_rs;
`ifdef LCD_FOURBIT_EN
        single_q    <= 1'b0;
        force_clr_q <= 1'b0;
`endif
      end

`ifdef LCD_FOURBIT_EN
      if (load_init || load_wr) phase_lo <= 1'b0;
      else if (phase_set)       phase_lo <= 1'b1;
`endif

      if (state == S_SETUP) begin
        LCD_RS <= rs_q;
`ifdef LCD_FOURBIT_EN
        LCD_DATA <= phase_lo ? {byte_q[3:0], 4'h0} : {byte_q[7:4], 4'h0};
`else
        LCD_DATA <= byte_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: expected EN pulses are queued when stimulus is driven
// and compared against pulses captured from the LCD pins. Honours LCD_FOURBIT_EN.
module tb_lcd_hd44780_ctrl;

  localparam int PWRUP = 20;
  localparam int H     = 3;
  localparam int CMD   = 10;
  localparam int CLR   = 40;
`ifdef LCD_FOURBIT_EN
  localparam int NIB_EXTRA = 1 + H;
`else
  localparam int NIB_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, LCD_RS, LCD_RW, LCD_EN;
  logic [7:0] LCD_DATA;

  lcd_hd44780_ctrl #(
    .PWRUP_WAIT_CYC(PWRUP),
    .EN_HIGH_CYC   (H),
    .CMD_WAIT_CYC  (CMD),
    .CLR_WAIT_CYC  (CLR),
    .ENTRY_MODE    (8'h06)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .init_done(init_done),
    .LCD_DATA (LCD_DATA),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       gap_chk;
    int         gap;
  } exp_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    int         high;
    int         low;
    logic       setup_ok;
    logic       stable_ok;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs[256];
  int   obs_wr = 0;
  int   obs_rd = 0;
  int   fall_cyc = 0;
  int   rise_cyc = 0;

  // Pin monitor: one record per completed EN pulse (high width, preceding low gap, setup/hold)
  logic       en_prev = 1'b0, rs_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  obs_t       cur;
  int         low_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      en_prev = 1'b0;
      low_cnt = 0;
    end else begin
      if (LCD_EN && !en_prev) begin
        cur.rs        = LCD_RS;
        cur.data      = LCD_DATA;
        cur.high      = 1;
        cur.low       = low_cnt;
        cur.setup_ok  = (LCD_DATA === data_prev) && (LCD_RS === rs_prev);
        cur.stable_ok = 1'b1;
        rise_cyc      = cyc;
      end else if (LCD_EN) begin
        cur.high = cur.high + 1;
        if (LCD_DATA !== cur.data || LCD_RS !== cur.rs) cur.stable_ok = 1'b0;
      end else if (en_prev) begin
        obs[obs_wr % 256] = cur;
        obs_wr   = obs_wr + 1;
        fall_cyc = cyc;
        low_cnt  = 1;
      end else begin
        low_cnt = low_cnt + 1;
      end
      en_prev   = LCD_EN;
      data_prev = LCD_DATA;
      rs_prev   = LCD_RS;
    end
  end

  task automatic push_pulse(input logic rs, input logic [7:0] data, input int gap);
    exp_q.push_back('{rs: rs, data: data, gap_chk: (gap >= 0), gap: gap});
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] data, input int gap);
`ifdef LCD_FOURBIT_EN
    push_pulse(rs, {data[7:4], 4'h0}, gap);
    push_pulse(rs, {data[3:0], 4'h0}, 1);
`else
    push_pulse(rs, data, gap);
`endif
  endtask

  // Init gap = settle wait plus the one-cycle setup of the next entry
  task automatic push_init();
`ifdef LCD_FOURBIT_EN
    push_pulse(1'b0, 8'h30, -1);
    push_pulse(1'b0, 8'h30, CLR + 1);
    push_pulse(1'b0, 8'h30, CMD + 1);
    push_pulse(1'b0, 8'h20, CMD + 1);
    push_byte(1'b0, 8'h28, CMD + 1);
    push_byte(1'b0, 8'h0C, CMD + 1);
    push_byte(1'b0, 8'h01, CMD + 1);
    push_byte(1'b0, 8'h06, CLR + 1);
`else
    push_byte(1'b0, 8'h38, -1);
    push_byte(1'b0, 8'h0C, CMD + 1);
    push_byte(1'b0, 8'h01, CMD + 1);
    push_byte(1'b0, 8'h06, CLR + 1);
`endif
  endtask

  task automatic check_pulses(input string name);
    obs_t o;
    exp_t e;
    while (obs_rd < obs_wr) begin
      o = obs[obs_rd % 256];
      obs_rd++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s unexpected_pulse: got rs=%0b data=%02h, expected no pulse", name, o.rs, o.data);
        continue;
      end
      e = exp_q.pop_front();
      if (o.rs !== e.rs || o.data !== e.data) begin
        n_fail++;
        $display("FAIL %s pulse_value: got rs=%0b data=%02h, expected rs=%0b data=%02h",
                 name, o.rs, o.data, e.rs, e.data);
      end
      n_tests++;
      if (o.high != H) begin
        n_fail++;
        $display("FAIL %s en_width: got %0d, expected %0d (data %02h)", name, o.high, H, e.data);
      end
      n_tests++;
      if (!o.setup_ok || !o.stable_ok) begin
        n_fail++;
        $display("FAIL %s setup_hold: got setup=%0b stable=%0b, expected 1/1 (data %02h)",
                 name, o.setup_ok, o.stable_ok, e.data);
      end
      if (e.gap_chk) begin
        n_tests++;
        if (o.low != e.gap) begin
          n_fail++;
          $display("FAIL %s en_low_gap: got %0d, expected %0d (data %02h)", name, o.low, e.gap, e.data);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_pulses: got %0d outstanding, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // Caller must be at a negedge; returns at the first negedge with wr_ready high
  task automatic wait_ready(input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wr_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s ready_timeout: got wr_ready=%0b after %0d cycles, expected 1", name, wr_ready, budget);
  endtask

  // Entered with rst held, at a negedge
  task automatic run_init(input string name);
    bit ok, quiet;
    int i;
    exp_q.delete();
    obs_rd = obs_wr;
    push_init();
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < PWRUP; k++) begin
      @(negedge clk);
      if (LCD_EN !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL %s pwrup_quiet: got EN high within %0d cycles, expected low", name, PWRUP);
    end
    i = 0;
    while (init_done !== 1'b1 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    n_tests++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s init_done_timeout: got %0b, expected 1", name, init_done);
    end
    check_pulses(name);
    wait_ready(200, name, ok);
    if (ok) begin
      n_tests++;
      if (cyc - fall_cyc != CMD) begin
        n_fail++;
        $display("FAIL %s init_ready_delay: got %0d, expected %0d", name, cyc - fall_cyc, CMD);
      end
      n_tests++;
      if (init_done !== 1'b1) begin
        n_fail++;
        $display("FAIL %s init_done_sticky: got %0b, expected 1", name, init_done);
      end
    end
  endtask

  task automatic do_write(input logic rs, input logic [7:0] data, input int exp_wait, input string name);
    bit ok;
    int hs;
    wait_ready(2000, name, ok);
    if (!ok) return;
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = data;
    push_byte(rs, data, -1);
    @(negedge clk);
    hs = cyc;
    wr_valid = 1'b0;
    wr_data  = 8'($urandom);
    wr_rs    = 1'($urandom);
    n_tests++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_drop: got %0b, expected 0", name, wr_ready);
    end
    // Requests while busy must be ignored
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      wr_rs    = 1'($urandom);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_ready(2000, name, ok);
    if (!ok) return;
    n_tests++;
    if (cyc - fall_cyc != exp_wait) begin
      n_fail++;
      $display("FAIL %s settle: got %0d, expected %0d", name, cyc - fall_cyc, exp_wait);
    end
    n_tests++;
    if (cyc - hs != 2 + H + NIB_EXTRA + exp_wait) begin
      n_fail++;
      $display("FAIL %s hs_to_ready: got %0d, expected %0d", name, cyc - hs, 2 + H + NIB_EXTRA + exp_wait);
    end
    n_tests++;
    if (rise_cyc - hs != 2 + NIB_EXTRA) begin
      n_fail++;
      $display("FAIL %s en_rise: got %0d, expected %0d", name, rise_cyc - hs, 2 + NIB_EXTRA);
    end
    check_pulses(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({LCD_EN, LCD_RW, LCD_RS, LCD_DATA, wr_ready, init_done} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%0b rw=%0b rs=%0b data=%02h ready=%0b done=%0b, expected all 0",
               LCD_EN, LCD_RW, LCD_RS, LCD_DATA, wr_ready, init_done);
    end
    run_init("init");
  endtask

  task automatic test_cmd_write();
    do_write(1'b0, 8'h80, CMD, "cmd_80");
  endtask

  task automatic test_settle_select();
    do_write(1'b1, 8'h01, CMD, "data_01");
    do_write(1'b0, 8'h01, CLR, "cmd_clear");
    do_write(1'b0, 8'h02, CLR, "cmd_home");
    do_write(1'b0, 8'h03, CLR, "cmd_03");
    do_write(1'b0, 8'h04, CMD, "cmd_04");
    do_write(1'b0, 8'h00, CMD, "cmd_00");
    do_write(1'b1, 8'h03, CMD, "data_03");
  endtask

`ifdef LCD_FOURBIT_EN
  task automatic test_fourbit();
    do_write(1'b1, 8'hA5, CMD, "nib_a5");
  endtask
`endif

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] bytes [3];
    bytes[0] = 8'h41;
    bytes[1] = 8'h42;
    bytes[2] = 8'h43;
    wait_ready(2000, "b2b", ok);
    if (!ok) return;
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = bytes[0];
    push_byte(1'b1, bytes[0], -1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b ready_drop_%0d: got %0b, expected 0", k, wr_ready);
      end
      if (k < 2) begin
        wr_data = bytes[k + 1];
        push_byte(1'b1, bytes[k + 1], CMD + 3);
      end else begin
        wr_valid = 1'b0;
      end
      wait_ready(2000, "b2b", ok);
      if (!ok) return;
      n_tests++;
      if (cyc - fall_cyc != CMD) begin
        n_fail++;
        $display("FAIL b2b settle_%0d: got %0d, expected %0d", k, cyc - fall_cyc, CMD);
      end
    end
    check_pulses("b2b");
  endtask

  task automatic test_reset_mid_strobe();
    bit ok;
    int i;
    wait_ready(2000, "rst_mid", ok);
    if (!ok) return;
    wr_valid = 1'b1;
    wr_rs    = 1'b0;
    wr_data  = 8'hC0;
    @(negedge clk);
    wr_valid = 1'b0;
    i = 0;
    while (LCD_EN !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    n_tests++;
    if (LCD_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid en_timeout: got %0b, expected 1", LCD_EN);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (LCD_EN !== 1'b0 || init_done !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid async_clear: got en=%0b done=%0b ready=%0b, expected 0/0/0",
               LCD_EN, init_done, wr_ready);
    end
    @(negedge clk);
    run_init("reinit");
  endtask

  initial begin
    test_reset();
    test_cmd_write();
    test_settle_select();
`ifdef LCD_FOURBIT_EN
    test_fourbit();
`endif
    test_back_to_back();
    test_reset_mid_strobe();
    test_cmd_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
